// File: rtl/transition_sweep_checker_pkg.sv
// Shared types for the transition sweep checker: sweep FSM encoding and the
// saturating toggle-count type used by the hazard classifier.
package transition_sweep_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FROM = 2'd1,
    ST_TO   = 2'd2,
    ST_DONE = 2'd3
  } sweep_state_e;

  // Toggles seen during one TO phase; three or more all look the same.
  typedef logic [1:0] toggle_cnt_t;

  localparam toggle_cnt_t TOGGLE_MAX = 2'd3;

  function automatic toggle_cnt_t toggle_inc(input toggle_cnt_t cnt);
    return (cnt == TOGGLE_MAX) ? cnt : cnt + 2'd1;
  endfunction

endpackage

// File: rtl/transition_sweep_checker_if.sv
// Bus between the sweep checker (slave) and the harness that owns the
// circuit under test (master).
interface transition_sweep_checker_if #(
  parameter int N  = 3,
  parameter int CW = 16
);

  logic          start;
  logic [N-1:0]  stim;
  logic          dut_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] static_cnt;
  logic [CW-1:0] dynamic_cnt;
  logic          first_valid;
  logic [N-1:0]  first_from;
  logic [N-1:0]  first_to;

  modport master (
    output start, dut_out,
    input  stim, busy, done, static_cnt, dynamic_cnt,
           first_valid, first_from, first_to
  );

  modport slave (
    input  start, dut_out,
    output stim, busy, done, static_cnt, dynamic_cnt,
           first_valid, first_from, first_to
  );

endinterface

// File: rtl/transition_sweep_checker_hazard_classifier.sv
// Watches the DUT output through one TO phase, counts output toggles
// against the previous sample, and flags a static or dynamic hazard on the
// final TO edge. The hit outputs are combinational so the counter update
// lands on that same final edge.
module transition_sweep_checker_hazard_classifier
  import transition_sweep_checker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic from_last,   // last edge of the FROM phase
  input  logic to_step,     // every edge of the TO phase
  input  logic to_last,     // last edge of the TO phase
  input  logic dut_out,
  input  logic ref_val,     // output level settled under the FROM vector
  output logic static_hit,
  output logic dynamic_hit
);

  logic        prev_q;
  toggle_cnt_t tog_q;
  toggle_cnt_t tog_next;

  // Toggle count including the sample taken on this edge, and the verdict.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    tog_next    = tog_q;
    static_hit  = 1'b0;
    dynamic_hit = 1'b0;
    if (dut_out != prev_q) begin
      tog_next = toggle_inc(tog_q);
    end
    if (to_last) begin
      static_hit  = (dut_out == ref_val) && (tog_next != 2'd0);
      dynamic_hit = (dut_out != ref_val) && (tog_next >= 2'd2);
    end
  end

  // Previous-sample and toggle registers; armed with the reference level.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    if (rst) begin
      prev_q <= 1'b0;
      tog_q  <= '0;
    end else if (from_last) begin
      prev_q <= dut_out;
      tog_q  <= '0;
    end else if (to_step) begin
      prev_q <= dut_out;
      tog_q  <= tog_next;
    end
  end

endmodule

// File: rtl/transition_sweep_checker.sv
// Exhaustive ordered-pair transition sweep for an N-input combinational
// circuit. For offset i = 1..2^N-1 and from-vector j = 0..2^N-1 it holds j
// for HOLD cycles, then (j+i) mod 2^N for HOLD cycles, and counts the static
// and dynamic hazards the classifier reports, keeping the first offender.
module transition_sweep_checker
  import transition_sweep_checker_pkg::*;
#(
  parameter int N    = 3,
  parameter int HOLD = 7,
  parameter int CW   = 16
) (
  input logic                 clk,
  input logic                 rst,
  transition_sweep_checker_if.slave bus
);

  localparam int V  = 1 << N;
  localparam int P  = (V - 1) * V;
  localparam int HW = $clog2(HOLD);
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  localparam logic [N-1:0]  VEC_MAX   = '1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [PW-1:0] PAIR_LAST = PW'(P - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  sweep_state_e  state_q, state_d;
  logic [HW-1:0] hold_q;
  logic [PW-1:0] pair_q;
  logic [N-1:0]  off_q;
  logic [N-1:0]  from_q;
  logic [N-1:0]  stim_q;
  logic          ref_q;
  logic [CW-1:0] static_q;
  logic [CW-1:0] dynamic_q;
  logic          first_valid_q;
  logic [N-1:0]  first_from_q;
  logic [N-1:0]  first_to_q;

  logic in_sweep;
  logic start_ok;
  logic phase_last;
  logic from_last;
  logic to_step;
  logic to_last;
  logic sweep_last;
  logic static_hit;
  logic dynamic_hit;

  assign in_sweep   = (state_q == ST_FROM) || (state_q == ST_TO);
  assign start_ok   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign phase_last = in_sweep && (hold_q == HOLD_LAST);
  assign from_last  = (state_q == ST_FROM) && phase_last;
  assign to_step    = (state_q == ST_TO);
  assign to_last    = to_step && phase_last;
  assign sweep_last = to_last && (pair_q == PAIR_LAST);

  // Sweep FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sweep FSM next state: phases alternate until the last pair's TO phase.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_ok)   state_d = ST_FROM;
      ST_FROM: if (phase_last) state_d = ST_TO;
      ST_TO:   if (phase_last) state_d = sweep_last ? ST_DONE : ST_FROM;
      ST_DONE: if (start_ok)   state_d = ST_FROM;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Cycle-within-phase counter; sits at zero outside a sweep.
  always_ff @(posedge clk) begin
    if (rst || !in_sweep || phase_last) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_q + 1'b1;
    end
  end

  // Pair pointers and the stimulus vector, stepped at phase boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_q  <= '0;
      from_q <= '0;
      pair_q <= '0;
      stim_q <= '0;
    end else if (start_ok) begin
      off_q  <= N'(1);
      from_q <= '0;
      pair_q <= '0;
      stim_q <= '0;
    end else if (from_last) begin
      stim_q <= from_q + off_q;
    end else if (to_last && !sweep_last) begin
      pair_q <= pair_q + 1'b1;
      from_q <= from_q + 1'b1;
      stim_q <= from_q + 1'b1;
      if (from_q == VEC_MAX) begin
        off_q <= off_q + 1'b1;
      end
    end
  end

  // Reference level: the output as the FROM phase ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= 1'b0;
    end else if (from_last) begin
      ref_q <= bus.dut_out;
    end
  end

  transition_sweep_checker_hazard_classifier u_classifier (
    .clk         (clk),
    .rst         (rst),
    .from_last   (from_last),
    .to_step     (to_step),
    .to_last     (to_last),
    .dut_out     (bus.dut_out),
    .ref_val     (ref_q),
    .static_hit  (static_hit),
    .dynamic_hit (dynamic_hit)
  );

  // Saturating hazard counters and first-offender capture.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      static_q      <= '0;
      dynamic_q     <= '0;
      first_valid_q <= 1'b0;
      first_from_q  <= '0;
      first_to_q    <= '0;
    end else begin
      if (static_hit && (static_q != CNT_MAX)) begin
        static_q <= static_q + 1'b1;
      end
      if (dynamic_hit && (dynamic_q != CNT_MAX)) begin
        dynamic_q <= dynamic_q + 1'b1;
      end
      if ((static_hit || dynamic_hit) && !first_valid_q) begin
        first_valid_q <= 1'b1;
        first_from_q  <= from_q;
        first_to_q    <= from_q + off_q;
      end
    end
  end

  assign bus.stim        = stim_q;
  assign bus.busy        = in_sweep;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.static_cnt  = static_q;
  assign bus.dynamic_cnt = dynamic_q;
  assign bus.first_valid = first_valid_q;
  assign bus.first_from  = first_from_q;
  assign bus.first_to    = first_to_q;

endmodule

// File: doc/transition_sweep_checker.md
# transition_sweep_checker

Parametrised, clocked successor to our exhaustive hazard-sweep benches. It drives every ordered input-vector pair (from, to) of an N-input combinational circuit under test, holds each vector for HOLD cycles, and samples the circuit output every cycle. It classifies static and dynamic hazards, counts them, and captures the first offending transition. It sits beside any combinational DUT in simulation or on an FPGA board, replacing hand-written nested stimulus loops.

## Interface
- N, 3, DUT input width; 1..8
- HOLD, 7, cycles each vector is held; ≥2
- CW, 16, hazard counter width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin sweep; ignored while busy
- stim  out  N  vector driven to the DUT
- dut_out  in  1  DUT output, sampled every clk
- busy  out  1  high from start acceptance until sweep end
- done  out  1  high after sweep completes, cleared by next accepted start or rst
- static_cnt  out  CW  static hazards found (saturating)
- dynamic_cnt  out  CW  dynamic hazards found (saturating)
- first_valid  out  1  a hazard has been captured
- first_from, first_to  out  N each  vectors of the first hazard

## Operation
- Sweep order: for i = 1..2^N−1, for j = 0..2^N−1: FROM phase stim=j, then TO phase stim=(j+i) mod 2^N. Total pairs P=(2^N−1)·2^N.
- FSM: IDLE → FROM (on start) → TO → FROM (next pair) … → DONE after the last TO phase; DONE → FROM on start (clears counters, done, first_*); rst → IDLE from any state.
- Each phase lasts exactly HOLD cycles; stim updates on the edge entering the phase.
- ref = dut_out sampled on the last edge of FROM.
- In TO, each edge compares dut_out with the previous sample (initially ref), counting toggles (2-bit, saturating at 3).
- Classification on the last TO edge, using final = that sample:
  - static hazard: final==ref and toggles≥1 (toggles is even, ≥2)
  - dynamic hazard: final≠ref and toggles≥2
  - otherwise clean
- On a hazard, increment the matching counter, saturating at 2^CW−1. If first_valid=0, capture first_from=j, first_to=(j+i) mod 2^N, and set first_valid.
- Only one-cycle-or-longer output excursions are visible. Sub-cycle glitches are out of scope and require the DUT model to express its delays in clk cycles.

## Timing
- Reset values: stim=0, busy=0, done=0, static_cnt=0, dynamic_cnt=0, first_valid=0, first_from=0, first_to=0, FSM=IDLE.
- start sampled high in IDLE/DONE: next edge → FROM, busy=1, stim=0, done=0, counters cleared.
- Sweep length: exactly 2·HOLD·P cycles from the FROM entry to the DONE entry. On the DONE-entry edge, busy=0 and done=1 together.
- The last classification and counter update land on the same edge as the DONE entry.
- start while busy: ignored, no effect.
- rst mid-sweep: all state returns to reset values on that edge; a partial pair is not classified.
- Hazard on the same pair as a counter at saturation: counter holds; capture logic is unaffected.

## Structure
- Shared package: FSM state encoding (IDLE, FROM, TO, DONE) and the 2-bit toggle-count type. P and the hold-counter width ($clog2(HOLD)) are derived as localparams in the module.
- One natural sub-module: hazard_classifier. Inputs are clk, rst, phase strobes, dut_out and ref. Outputs are a static/dynamic pulse on the final TO edge. The sweep FSM and counters stay in the top.
- Target size: roughly 150–250 lines of RTL.

## Test plan
- N=3, HOLD=7, DUT=stim[2]&stim[0] → done 784 cycles after FROM entry; static_cnt=0, dynamic_cnt=0, first_valid=0.
- N=3, HOLD=7, DUT=(a&c | b&~c) with the ~c path delayed 2 cycles → static_cnt>0. The first capture is the earliest 1→1 pair across a c change in sweep order, with the expected from/to computed by the bench model.
- Bench forces dut_out 0→1→0→1 within the TO phase of pair 0→7 (final≠ref) → dynamic_cnt=1, first_from=0, first_to=7.
- rst asserted 100 cycles into a sweep → all outputs at reset values next edge. A fresh start then gives results identical to a clean run.
- start pulsed while busy, then again in DONE → the first pulse is ignored (sweep length unchanged). The second pulse clears done and the counters and repeats the sweep.
- CW=2 with a DUT hazarding on every pair → static_cnt saturates at 3 and never wraps.
